// File: rtl/im_boot_loader_pkg.sv
// Shared constants and types for the instruction-memory boot loader.
package im_boot_loader_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h4000_0009;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } boot_state_t;

  // Word fetches must sit on a 4-byte boundary.
  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/im_boot_loader_if.sv
// Streaming valid/ready program-load channel into the boot loader.
interface im_boot_loader_if;
  import im_boot_loader_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [INST_W-1:0] load_data;
  logic              load_last;

  modport master (output load_valid, output load_data, output load_last, input  load_ready);
  modport slave  (input  load_valid, input  load_data, input  load_last, output load_ready);
endinterface

// File: rtl/im_boot_loader_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one combinational read port.
module im_boot_loader_array
  import im_boot_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/im_boot_loader.sv
// Fills instruction memory from a load stream, holds the core in reset meanwhile,
// then serves combinational fetches at the core PC.
module im_boot_loader
  import im_boot_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  im_boot_loader_if.slave     load,
  input  logic                reload,
  input  logic [PC_W-1:0]     pc_addr,
  output logic [INST_W-1:0]   im_out,
  output logic                core_rst,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  boot_state_t       state_r, next_state_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   word_count_r;
  logic              overflow_r;
  logic              load_ready_r, core_rst_r, done_r;
  logic              wr_en_s, clear_s, set_ovf_s;
  logic [ADDR_W-1:0] idx_s;
  logic [INST_W-1:0] rdata_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and load-side control.
  always_comb begin
    next_state_s = state_r;
    wr_en_s      = 1'b0;
    clear_s      = 1'b0;
    set_ovf_s    = 1'b0;
    case (state_r)
      LOAD: begin
        if (load.load_valid && load_ready_r) begin
          wr_en_s = 1'b1;
          if (load.load_last) begin
            next_state_s = RELEASE;
          end else if (wr_ptr_r == LAST_IDX) begin
            next_state_s = RELEASE;
            set_ovf_s    = 1'b1;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = LOAD;
        end
      end
      RELEASE: next_state_s = RUN;
      RUN: begin
        if (reload) begin
          next_state_s = LOAD;
          clear_s      = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = LOAD;
    endcase
  end

  // Write pointer, word counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      word_count_r <= '0;
      overflow_r   <= 1'b0;
    end else if (clear_s) begin
      wr_ptr_r     <= '0;
      word_count_r <= '0;
      overflow_r   <= 1'b0;
    end else if (wr_en_s) begin
      // The pointer parks on the last slot; leaving LOAD stops further writes.
      if (wr_ptr_r != LAST_IDX) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      word_count_r <= word_count_r + CNT_ONE;
      overflow_r   <= overflow_r | set_ovf_s;
    end else begin
      wr_ptr_r     <= wr_ptr_r;
      word_count_r <= word_count_r;
      overflow_r   <= overflow_r;
    end
  end

  // State-decoded outputs, registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ready_r <= 1'b1;
      core_rst_r   <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      load_ready_r <= (next_state_s == LOAD);
      core_rst_r   <= (next_state_s != RUN);
      done_r       <= (next_state_s == RUN);
    end
  end

  im_boot_loader_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (load.load_data),
    .raddr (idx_s),
    .rdata (rdata_s)
  );

  assign idx_s = pc_addr[ADDR_W+1:2];

  // Fetch gating: anything not a loaded, aligned, in-range word in RUN reads as NOP.
  always_comb begin
    im_out = NOP_INST;
    if (word_aligned(pc_addr[1:0]) && (pc_addr[PC_W-1:ADDR_W+2] == '0) &&
        ({1'b0, idx_s} < word_count_r) && (state_r == RUN)) begin
      im_out = rdata_s;
    end else begin
      im_out = NOP_INST;
    end
  end

  assign load.load_ready = load_ready_r;
  assign core_rst        = core_rst_r;
  assign done            = done_r;
  assign word_count      = word_count_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed self-checking bench: a DEPTH=1024 instance for the main flows and a DEPTH=8 one for overflow.
module tb_im_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0, reload8 = 1'b0;
  logic [31:0] pc_addr = 32'h0, pc8 = 32'h0;
  logic [31:0] im_out, im_out8;
  logic        core_rst, done, overflow, core_rst8, done8, overflow8;
  logic [10:0] word_count;
  logic [3:0]  word_count8;
  int          checks = 0;
  int          failures = 0;

  im_boot_loader_if ld ();
  im_boot_loader_if ld8 ();

  im_boot_loader dut (
    .clk(clk), .rst(rst), .load(ld), .reload(reload), .pc_addr(pc_addr),
    .im_out(im_out), .core_rst(core_rst), .done(done),
    .word_count(word_count), .overflow(overflow)
  );

  im_boot_loader #(.DEPTH(8), .ADDR_W(3), .PC_W(32)) dut8 (
    .clk(clk), .rst(rst), .load(ld8), .reload(reload8), .pc_addr(pc8),
    .im_out(im_out8), .core_rst(core_rst8), .done(done8),
    .word_count(word_count8), .overflow(overflow8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    ld.load_valid = 1'b1;
    ld.load_data  = d;
    ld.load_last  = last;
    tick();
    ld.load_valid = 1'b0;
    ld.load_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    checks++; if (ld.load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", ld.load_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (word_count !== 11'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL reset_im_out got=%h exp=40000009", im_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    push_word(32'h1111_1111, 1'b0);
    push_word(32'h2222_2222, 1'b0);
    push_word(32'h3333_3333, 1'b0);
    push_word(32'h4444_4444, 1'b1);
    checks++; if (word_count !== 11'd4) begin failures++; $display("FAIL basic_word_count got=%0d exp=4", word_count); end
    checks++; if (core_rst !== 1'b1 || ld.load_ready !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL basic_release got core_rst=%b ready=%b done=%b exp 1 0 0", core_rst, ld.load_ready, done); end
    reload = 1'b1;  // ignored outside RUN
    tick();
    reload = 1'b0;
    checks++; if (core_rst !== 1'b0 || done !== 1'b1) begin failures++;
      $display("FAIL basic_run got core_rst=%b done=%b exp 0 1", core_rst, done); end
    pc_addr = 32'h8; #1;
    checks++; if (im_out !== 32'h3333_3333) begin failures++; $display("FAIL basic_fetch_8 got=%h exp=33333333", im_out); end
    pc_addr = 32'h10; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL basic_fetch_10 got=%h exp=40000009", im_out); end
    pc_addr = 32'h0; #1;
    checks++; if (im_out !== 32'h1111_1111) begin failures++; $display("FAIL basic_fetch_0 got=%h exp=11111111", im_out); end
  endtask

  task automatic test_fetch_range();
    pc_addr = 32'h2; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL fetch_misaligned got=%h exp=40000009", im_out); end
    pc_addr = 32'h0000_1000; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL fetch_out_of_range got=%h exp=40000009", im_out); end
    pc_addr = 32'h4; #1;
    checks++; if (im_out !== 32'h2222_2222) begin failures++; $display("FAIL fetch_4 got=%h exp=22222222", im_out); end
  endtask

  task automatic test_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checks++; if (core_rst !== 1'b1 || done !== 1'b0 || ld.load_ready !== 1'b1) begin failures++;
      $display("FAIL reload_state got core_rst=%b done=%b ready=%b exp 1 0 1", core_rst, done, ld.load_ready); end
    checks++; if (word_count !== 11'd0) begin failures++; $display("FAIL reload_word_count got=%0d exp=0", word_count); end
    pc_addr = 32'h0; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL reload_fetch_in_load got=%h exp=40000009", im_out); end
    push_word(32'hAAAA_0001, 1'b0);
    push_word(32'hAAAA_0002, 1'b1);
    checks++; if (word_count !== 11'd2) begin failures++; $display("FAIL reload_count2 got=%0d exp=2", word_count); end
    tick();
    pc_addr = 32'h8; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL reload_fetch_8 got=%h exp=40000009", im_out); end
    pc_addr = 32'h4; #1;
    checks++; if (im_out !== 32'hAAAA_0002) begin failures++; $display("FAIL reload_fetch_4 got=%h exp=aaaa0002", im_out); end
  endtask

  task automatic test_gaps();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    push_word(32'h1111_1111, 1'b0);
    push_word(32'h2222_2222, 1'b0);
    for (int g = 0; g < 3; g++) begin
      ld.load_data = 32'hDEAD_BEEF;
      tick();
      checks++; if (word_count !== 11'd2 || ld.load_ready !== 1'b1) begin failures++;
        $display("FAIL gap_hold%0d got count=%0d ready=%b exp 2 1", g, word_count, ld.load_ready); end
    end
    push_word(32'h3333_3333, 1'b0);
    push_word(32'h4444_4444, 1'b1);
    checks++; if (word_count !== 11'd4) begin failures++; $display("FAIL gap_word_count got=%0d exp=4", word_count); end
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w;
      exp_w = {4{(i[7:0] + 8'd1) * 8'h11}} & 32'hFFFF_FFFF;
      pc_addr = 32'(i * 4); #1;
      checks++; if (im_out !== exp_w) begin failures++; $display("FAIL gap_fetch%0d got=%h exp=%h", i, im_out, exp_w); end
    end
  endtask

  task automatic test_overflow();
    int accepted;
    logic rdy;
    accepted = 0;
    for (int i = 1; i <= 10; i++) begin
      ld8.load_valid = 1'b1;
      ld8.load_data  = 32'hB000_0000 + 32'(i);
      ld8.load_last  = 1'b0;
      rdy = ld8.load_ready;
      checks++; if (rdy !== (i <= 8)) begin failures++; $display("FAIL ovf_ready_beat%0d got=%b exp=%b", i, rdy, (i <= 8)); end
      if (rdy === 1'b1) accepted++;
      tick();
    end
    ld8.load_valid = 1'b0;
    checks++; if (accepted != 8) begin failures++; $display("FAIL ovf_accepted got=%0d exp=8", accepted); end
    checks++; if (word_count8 !== 4'd8 || overflow8 !== 1'b1) begin failures++;
      $display("FAIL ovf_flags got count=%0d ovf=%b exp 8 1", word_count8, overflow8); end
    checks++; if (done8 !== 1'b1 || core_rst8 !== 1'b0) begin failures++;
      $display("FAIL ovf_run got done=%b core_rst=%b exp 1 0", done8, core_rst8); end
    pc8 = 32'h1C; #1;
    checks++; if (im_out8 !== 32'hB000_0008) begin failures++; $display("FAIL ovf_fetch_1c got=%h exp=b0000008", im_out8); end
    pc8 = 32'h20; #1;
    checks++; if (im_out8 !== 32'h4000_0009) begin failures++; $display("FAIL ovf_fetch_20 got=%h exp=40000009", im_out8); end
  endtask

  task automatic test_async_reset();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    push_word(32'h5555_0001, 1'b0);
    push_word(32'h5555_0002, 1'b0);
    push_word(32'h5555_0003, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (word_count !== 11'd0 || core_rst !== 1'b1 || ld.load_ready !== 1'b1 || done !== 1'b0) begin failures++;
      $display("FAIL arst_immediate got count=%0d core_rst=%b ready=%b done=%b exp 0 1 1 0", word_count, core_rst, ld.load_ready, done); end
    checks++; if (overflow8 !== 1'b0 || word_count8 !== 4'd0) begin failures++;
      $display("FAIL arst_dut8 got ovf=%b count=%0d exp 0 0", overflow8, word_count8); end
    #2;
    rst = 1'b0;
    tick();
    push_word(32'h6666_0001, 1'b0);
    push_word(32'h6666_0002, 1'b1);
    tick();
    checks++; if (word_count !== 11'd2 || done !== 1'b1) begin failures++;
      $display("FAIL arst_reload_state got count=%0d done=%b exp 2 1", word_count, done); end
    pc_addr = 32'h0; #1;
    checks++; if (im_out !== 32'h6666_0001) begin failures++; $display("FAIL arst_fetch_0 got=%h exp=66660001", im_out); end
    pc_addr = 32'h8; #1;
    checks++; if (im_out !== 32'h4000_0009) begin failures++; $display("FAIL arst_fetch_8 got=%h exp=40000009", im_out); end
  endtask

  initial begin
    ld.load_valid  = 1'b0;
    ld.load_data   = 32'h0;
    ld.load_last   = 1'b0;
    ld8.load_valid = 1'b0;
    ld8.load_data  = 32'h0;
    ld8.load_last  = 1'b0;
    test_reset();
    test_basic_load();
    test_fetch_range();
    test_reload();
    test_gaps();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
